instruction_fetch: RTL

Program-counter and instruction-register stage sitting between the combinational instruction ROM and the execute/ALU stage. Drives the ROM address and registers the returned 28-bit instruction for execute. Resolves NOP delays (24-bit cycle count) and unconditional jumps locally. Handles BLE branches by waiting one cycle for the execute stage's compare result.

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Program-counter / instruction-register stage between a
//             combinational instruction ROM and the execute stage. Resolves
//             NOP delays and unconditional jumps locally. Holds each BLE for
//             one extra cycle so that execute can return its compare result.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock         in   1   rising-edge clock
//    Reset         in   1   asynchronous active-high reset
//    oAddress      out  16  ROM address (the PC register)
//    iInstruction  in   28  ROM data for oAddress
//    oInstruction  out  28  registered instruction for execute
//    oValid        out  1   oInstruction is to be executed this cycle
//    iBranchTaken  in   1   BLE compare result, sampled in BR_WAIT only
//    oPC           out  16  address of the instruction on oInstruction
// ============================================================================
module instruction_fetch #(
  parameter logic [3:0] OPC_NOP = 4'd0,
  parameter logic [3:0] OPC_JMP = 4'd3,
  parameter logic [3:0] OPC_BLE = 4'd4
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iBranchTaken,
  output logic [15:0] oPC
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELAY   = 2'd1,
    BR_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [23:0] delay_count;

  logic [3:0]  fetch_opcode;
  logic [15:0] fetch_target;
  logic [23:0] fetch_nop_count;
  logic [15:0] held_target;

  assign oAddress        = pc;
  assign fetch_opcode    = iInstruction[27:24];
  assign fetch_target    = {8'd0, iInstruction[23:16]};
  assign fetch_nop_count = iInstruction[23:0];
  // In BR_WAIT the ROM already shows PC+1, so the branch target must come
  // from the BLE still held on oInstruction.
  assign held_target     = {8'd0, oInstruction[23:16]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc           <= 16'd0;
      oInstruction <= 28'd0;
      oValid       <= 1'b0;
      oPC          <= 16'd0;
      delay_count  <= 24'd0;
      state        <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          oInstruction <= iInstruction;
          oPC          <= pc;
          if (fetch_opcode == OPC_NOP) begin
            oValid <= 1'b0;
            pc     <= pc + 16'd1;
            if (fetch_nop_count != 24'd0) begin
              delay_count <= fetch_nop_count;
              state       <= DELAY;
            end
          end else if (fetch_opcode == OPC_JMP) begin
            // Jumps are resolved here and never issued to execute.
            oValid <= 1'b0;
            pc     <= fetch_target;
          end else if (fetch_opcode == OPC_BLE) begin
            oValid <= 1'b1;
            pc     <= pc + 16'd1;
            state  <= BR_WAIT;
          end else begin
            oValid <= 1'b1;
            pc     <= pc + 16'd1;
          end
        end

        DELAY: begin
          oValid      <= 1'b0;
          delay_count <= delay_count - 24'd1;
          if (delay_count == 24'd1) begin
            state <= FETCH;
          end
        end

        BR_WAIT: begin
          // Execute keeps seeing the BLE, but with oValid low.
          oValid <= 1'b0;
          if (iBranchTaken) begin
            pc <= held_target;
          end
          state <= FETCH;
        end

        default: begin
          oValid <= 1'b0;
          state  <= FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
